// File: rtl/game_pkg.sv
// Shared game constants: animation states, sprite frame indices and default sprite geometry.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } anim_state_t;

  localparam logic [2:0] FR_IDLE  = 3'd0;
  localparam logic [2:0] FR_WALK0 = 3'd1;
  localparam logic [2:0] FR_JUMP  = 3'd5;
  localparam logic [2:0] FR_FALL  = 3'd6;

  localparam int SPR_W_DEF = 16;
  localparam int SPR_H_DEF = 32;

  // Sprite-sheet frame for a given motion state; walk frames run FR_WALK0..FR_WALK0+3.
  function automatic logic [2:0] frame_of(anim_state_t st, logic [1:0] phase);
    case (st)
      WALK:    frame_of = FR_WALK0 + {1'b0, phase};
      JUMP:    frame_of = FR_JUMP;
      FALL:    frame_of = FR_FALL;
      default: frame_of = FR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/player_animator_if.sv
// Player position/keys and VGA draw coordinate in; animation state and sprite lookup out.
interface player_animator_if;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic [9:0]  BallW;
  logic [9:0]  BallH;
  logic        move_left;
  logic        move_right;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [1:0]  anim_state;
  logic        facing_left;
  logic [2:0]  sprite_frame;
  logic        is_player;
  logic [11:0] sprite_addr;

  // Plain level signals sampled every frame_clk rise; no valid/ready handshake.
  modport master (
    output BallX, BallY, BallW, BallH, move_left, move_right, DrawX, DrawY,
    input  anim_state, facing_left, sprite_frame, is_player, sprite_addr
  );
  modport slave (
    input  BallX, BallY, BallW, BallH, move_left, move_right, DrawX, DrawY,
    output anim_state, facing_left, sprite_frame, is_player, sprite_addr
  );
endinterface

// File: rtl/sprite_hit.sv
// Combinational box test around a centre point plus sprite-ROM address with optional mirroring.
module sprite_hit #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 32
) (
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  ball_w,
  input  logic [9:0]  ball_h,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        mirror,
  input  logic [2:0]  frame,
  output logic        hit,
  output logic [11:0] addr
);
  localparam logic signed [11:0] W_S     = 12'(SPR_W);
  localparam logic signed [11:0] H_S     = 12'(SPR_H);
  localparam logic [3:0]         COL_MAX = 4'(SPR_W - 1);

  logic signed [11:0] left, top, dx, dy;
  logic [3:0] col;
  logic [4:0] row;

  // Signed widening keeps a box that hangs off the left/top edge from wrapping.
  always_comb begin
    left = $signed({2'b00, ball_x}) - $signed({2'b00, ball_w});
    top  = $signed({2'b00, ball_y}) - $signed({2'b00, ball_h});
    dx   = $signed({2'b00, draw_x}) - left;
    dy   = $signed({2'b00, draw_y}) - top;
    hit  = (dx >= 12'sd0) && (dx < W_S) && (dy >= 12'sd0) && (dy < H_S);
    col  = mirror ? (COL_MAX - dx[3:0]) : dx[3:0];
    row  = dy[4:0];
    addr = hit ? {frame, row, col} : 12'h000;
  end
endmodule

// File: rtl/player_animator.sv
// Per-frame player motion classification, facing and walk-cycle tracking, plus per-pixel sprite lookup.
module player_animator
  import game_pkg::*;
#(
  parameter int WALK_DIV = 6,
  parameter int SPR_W    = SPR_W_DEF,
  parameter int SPR_H    = SPR_H_DEF
) (
  input logic               frame_clk,
  input logic               Reset_n,
  player_animator_if.slave  bus
);
  localparam logic [5:0] DIV_LAST = 6'(WALK_DIV - 1);

  anim_state_t state_q, state_d;
  logic        facing_q, facing_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  div_q, div_d;
  logic [9:0]  prev_y_q;
  logic        first_q;
  logic signed [9:0] dy;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      facing_q <= 1'b0;
      phase_q  <= 2'd0;
      div_q    <= 6'd0;
      prev_y_q <= 10'd0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      facing_q <= facing_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      prev_y_q <= bus.BallY;
      first_q  <= 1'b0;
    end
  end

  // The first frame after reset has no valid previous Y, so it never reads as vertical motion.
  always_comb begin
    dy       = first_q ? 10'sd0 : $signed(bus.BallY - prev_y_q);
    state_d  = IDLE;
    facing_d = facing_q;
    phase_d  = 2'd0;
    div_d    = 6'd0;

    if (dy < 10'sd0)                          state_d = JUMP;
    else if (dy > 10'sd0)                     state_d = FALL;
    else if (bus.move_left ^ bus.move_right)  state_d = WALK;

    if (bus.move_left && !bus.move_right)      facing_d = 1'b1;
    else if (bus.move_right && !bus.move_left) facing_d = 1'b0;

    if (state_q == WALK && state_d == WALK) begin
      if (div_q == DIV_LAST) begin
        div_d   = 6'd0;
        phase_d = phase_q + 2'd1;
      end else begin
        div_d   = div_q + 6'd1;
        phase_d = phase_q;
      end
    end
  end

  logic [2:0] frame;
  assign frame            = frame_of(state_q, phase_q);
  assign bus.anim_state   = state_q;
  assign bus.facing_left  = facing_q;
  assign bus.sprite_frame = frame;

  sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
    .ball_x (bus.BallX),
    .ball_y (bus.BallY),
    .ball_w (bus.BallW),
    .ball_h (bus.BallH),
    .draw_x (bus.DrawX),
    .draw_y (bus.DrawY),
    .mirror (facing_q),
    .frame  (frame),
    .hit    (bus.is_player),
    .addr   (bus.sprite_addr)
  );
endmodule

// File: tb/tb_player_animator.sv
// Self-checking bench for player_animator against a frame-level behavioural model.
module tb_player_animator;
  localparam int WALK_DIV = 6;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  player_animator_if bus ();

  player_animator #(.WALK_DIV(WALK_DIV)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state 0..3, walk_frames = frames spent in WALK since entering it.
  int m_state, m_face, m_walk_frames, m_prev_y, m_first;

  function automatic int exp_frame();
    case (m_state)
      1:       return 1 + ((m_walk_frames / WALK_DIV) % 4);
      2:       return 5;
      3:       return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] exp_vec();
    return {2'(m_state), 1'(m_face), 3'(exp_frame())};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.anim_state, bus.facing_left, bus.sprite_frame};
  endfunction

  task automatic model_reset();
    m_state = 0; m_face = 0; m_walk_frames = 0; m_prev_y = 0; m_first = 1;
  endtask

  task automatic model_tick();
    int dy, nxt;
    int l, r;
    l  = bus.move_left;
    r  = bus.move_right;
    dy = m_first ? 0 : int'(bus.BallY) - m_prev_y;
    if (dy < 0)       nxt = 2;
    else if (dy > 0)  nxt = 3;
    else if (l != r)  nxt = 1;
    else              nxt = 0;
    m_walk_frames = (nxt == 1 && m_state == 1) ? m_walk_frames + 1 : 0;
    if (l && !r) m_face = 1;
    if (r && !l) m_face = 0;
    m_state  = nxt;
    m_prev_y = bus.BallY;
    m_first  = 0;
  endtask

  task automatic tick();
    model_tick();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [12:0] exp_hit(int dx, int dy);
    int left, top, col, row;
    left = int'(bus.BallX) - int'(bus.BallW);
    top  = int'(bus.BallY) - int'(bus.BallH);
    if (dx < left || dx >= left + 16 || dy < top || dy >= top + 32) return 13'h0;
    col = dx - left;
    row = dy - top;
    if (m_face) col = 15 - col;
    return {1'b1, 12'(exp_frame() * 512 + row * 16 + col)};
  endfunction

  task automatic test_reset();
    Reset_n = 1'b0;
    bus.BallY = 10'd431;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_asserted got=%h want=%h", dut_vec(), exp_vec());
    end
    @(posedge frame_clk); #1;
    Reset_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.anim_state !== 2'd0) begin
      n_bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_walk();
    bus.move_right = 1'b1;
    for (int f = 0; f < 30; f++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL walk frame=%0d got=%h want=%h", f, dut_vec(), exp_vec());
      end
    end
    bus.move_right = 1'b0;
    tick();
  endtask

  task automatic test_jump_fall();
    for (int f = 0; f < 99; f++) begin
      if (f < 48)       bus.BallY = bus.BallY - 10'd1;
      else if (f < 96)  bus.BallY = bus.BallY + 10'd1;
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL jump_fall frame=%0d got=%h want=%h", f, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_facing();
    logic [1:0] keys [7] = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 7; i++) begin
      {bus.move_left, bus.move_right} = keys[i];
      tick();
      n_cmp++;
      if (bus.facing_left !== 1'(m_face) || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL facing step=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hit();
    int pts [4][2] = '{'{40, 415}, '{55, 446}, '{56, 446}, '{39, 420}};
    logic [12:0] got, want;
    bus.BallX = 10'd48; bus.BallY = 10'd431;
    for (int face = 0; face < 2; face++) begin
      {bus.move_left, bus.move_right} = face ? 2'b10 : 2'b01;
      tick();
      {bus.move_left, bus.move_right} = 2'b00;
      tick();
      for (int i = 0; i < 4; i++) begin
        bus.DrawX = 10'(pts[i][0]); bus.DrawY = 10'(pts[i][1]);
        #1;
        got  = {bus.is_player, bus.sprite_addr};
        want = exp_hit(pts[i][0], pts[i][1]);
        n_cmp++;
        if (got !== want) begin
          n_bad++; $display("FAIL hit face=%0d pt=%0d got=%h want=%h", face, i, got, want);
        end
      end
    end
    // Random boxes, including ones hanging off the left/top screen edge.
    for (int i = 0; i < 60; i++) begin
      bus.BallX = 10'($urandom_range(0, 60));
      bus.BallY = 10'($urandom_range(0, 60));
      {bus.move_left, bus.move_right} = 2'($urandom_range(0, 3));
      tick();
      bus.DrawX = 10'($urandom_range(0, 80));
      bus.DrawY = 10'($urandom_range(0, 100));
      #1;
      got  = {bus.is_player, bus.sprite_addr};
      want = exp_hit(int'(bus.DrawX), int'(bus.DrawY));
      n_cmp++;
      if (got !== want || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL hit_rand i=%0d got=%h/%h want=%h/%h", i, got, dut_vec(), want, exp_vec());
      end
    end
    {bus.move_left, bus.move_right} = 2'b00;
  endtask

  task automatic test_random();
    int d;
    bus.BallY = 10'd500;
    for (int f = 0; f < 300; f++) begin
      {bus.move_left, bus.move_right} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        d = int'($urandom_range(0, 4)) - 2;
        bus.BallY = 10'(int'(bus.BallY) + d);
      end
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random frame=%0d got=%h want=%h", f, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midwalk();
    bus.BallY = 10'd431;
    {bus.move_left, bus.move_right} = 2'b01;
    for (int f = 0; f < 2 * WALK_DIV + 2; f++) tick();
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.sprite_frame !== 3'd3) begin
      n_bad++; $display("FAIL midwalk_phase2 got=%h want=%h", dut_vec(), exp_vec());
    end
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL async_reset got=%h want=%h", dut_vec(), exp_vec());
    end
    #2 Reset_n = 1'b1;
    bus.BallY = 10'd300;
    tick();
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.anim_state[1] !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_first got=%h want=%h", dut_vec(), exp_vec());
    end
    tick();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL post_reset_second got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    bus.BallX = 10'd48;  bus.BallY = 10'd431;
    bus.BallW = 10'd8;   bus.BallH = 10'd16;
    bus.move_left = 1'b0; bus.move_right = 1'b0;
    bus.DrawX = 10'd0;   bus.DrawY = 10'd0;
    model_reset();
    test_reset();
    test_walk();
    test_jump_fall();
    test_facing();
    test_hit();
    test_random();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
